load_use_scoreboard: RTL
========================

# load_use_scoreboard

Parametrised load-use hazard unit for the 5-stage MIPS32 pipeline with a data memory of configurable fixed latency plus a variable-latency wait. It sits beside the IF/ID and ID/EX registers. A per-register pending-load scoreboard of down-counters stalls any consumer until the load data is forwardable. It also freezes the front of the pipe while memory is not ready, and ignores false hazards on `$0` and on non-read `rt` fields.

## Interface
- `REG_AW`, 5: register address width.
- `NUM_REGS`, 32: architectural registers; equals 2**REG_AW.
- `LOAD_LAT`, 2: extra cycles after a load enters MEM before its data is forwardable. Legal range 0..7.
- `clk`  in  1: pipeline clock.
- `rst`  in  1: reset. Synchronous and active-high.
- `id_ex_memread`  in  1: instruction in ID/EX is a load.
- `id_ex_rt`  in  REG_AW: load destination.
- `if_id_rs`  in  REG_AW: consumer source 1.
- `if_id_rt`  in  REG_AW: consumer source 2.
- `if_id_uses_rt`  in  1: consumer actually reads `rt` (R-type, store, beq/bne).
- `if_id_flush`  in  1: IF/ID is being squashed this cycle.
- `mem_ready`  in  1: data memory can advance. Low means wait.
- `hold_pc`  out  1: PC keeps its value.
- `if_id_hold`  out  1: IF/ID keeps its value.
- `id_ex_hold`  out  1: ID/EX keeps its value (memory wait only).
- `stall_en`  out  1: a bubble (control zeroed) is inserted into ID/EX.
- `stall_cycles`  out  32: saturating count of RAW-stall cycles. Present only with `HAZ_STALL_STATS_EN`.

## Operation
- Scoreboard: one counter `cnt[r]` per register, width clog2(LOAD_LAT+1). No storage when LOAD_LAT=0.
- Issue: when `id_ex_memread` & `id_ex_rt`≠0 & `mem_ready`, load `cnt[id_ex_rt]` ← LOAD_LAT at the clock edge. A newer load to the same register overwrites the counter.
- Decay: while `mem_ready`=1, every nonzero counter decrements by 1 per cycle. All counters hold while `mem_ready`=0.
- Simultaneous issue and decay on the same register: issue wins.
- Source match, per source s ∈ {rs; rt if `if_id_uses_rt`}. A source matches when s≠0 and either:
  - (`id_ex_memread` & `id_ex_rt`==s), or
  - `cnt[s]`≠0.
- `raw` = any source match & ~`if_id_flush`.
- Output priority:
  - `rst`: all outputs 0.
  - `mem_ready`=0: `hold_pc`=`if_id_hold`=`id_ex_hold`=1 and `stall_en`=0. The RAW bubble is deferred.
  - `raw`: `hold_pc`=`if_id_hold`=`stall_en`=1 and `id_ex_hold`=0.
  - Otherwise: all outputs 0.
- Outputs are combinational from the inputs and registered state. No registered outputs.
- Flush: suppresses stall outputs only. The scoreboard keeps tracking older loads.

## Timing
- Reset:
  - All counters clear on the first `clk` edge with `rst`=1.
  - `stall_cycles`=0.
  - Outputs are forced to 0 combinationally while `rst`=1.
  - Reset asserted mid-stall ends the stall in the same cycle.
- Load at ID/EX in cycle t with a dependent consumer at IF/ID: stall cycles = 1 + LOAD_LAT, given `mem_ready` held high. The consumer advances in cycle t+1+LOAD_LAT.
- Each cycle of `mem_ready`=0 lengthens any outstanding stall by exactly one cycle.
- LOAD_LAT=0 gives the classic single-cycle load-use bubble, with the `$0` and `uses_rt` qualifications.

## Configuration
- `HAZ_STALL_STATS_EN` defined:
  - `stall_cycles` increments by 1 each cycle `raw` & `mem_ready` & ~`rst`.
  - Saturates at 2^32−1 and clears on reset.
- `HAZ_STALL_STATS_EN` undefined: the port and the counter are absent. Stall behaviour is identical.

## Structure
- Package `hazard_pkg`:
  - REG_AW and NUM_REGS defaults.
  - `reg_addr_t` typedef.
  - `LOAD_LAT_MAX`=7.
  - Function `cnt_width(lat)`.
- Sub-module `sb_counter`, instantiated NUM_REGS times. Ports: `clk`, `rst`, `load`, `dec_en`, `busy`.

## Test plan
- LOAD_LAT=2. `lw $8` at ID/EX, consumer `add $9,$8,$1` at IF/ID, `mem_ready`=1 → `stall_en`/`hold_pc` high for exactly 3 cycles, low on the 4th.
- Same as above, with `mem_ready` low for 2 cycles during stall cycle 2 → `id_ex_hold`=1 and `stall_en`=0 in those cycles; 3 RAW-stall cycles total, consumer released 5 cycles after the start.
- `lw $0` followed by a consumer of `$0`, and `lw $5` followed by `addi $7,$6,1` with `if_id_rt`=5 and `uses_rt`=0 → no stall in either case.
- Dependent pair with `if_id_flush`=1 → outputs 0, and `cnt[8]`=2 in the next cycle. The following non-flushed consumer of `$8` stalls 2 cycles.
- Reset pulse in stall cycle 2 → outputs 0 the same cycle, all counters 0 the next cycle, no further stall.
- With `HAZ_STALL_STATS_EN`, run the first scenario twice → `stall_cycles`=6. After a reset → 0.

Source files
------------

// File: rtl/load_use_scoreboard_pkg.sv
// Shared types and sizing helpers for the load-use hazard unit.
// Optional stall statistics are enabled with HAZ_STALL_STATS_EN.
package hazard_pkg;

  localparam int unsigned REG_AW_DEF   = 5;
  localparam int unsigned NUM_REGS_DEF = 32;
  localparam int unsigned LOAD_LAT_MAX = 7;

  typedef logic [REG_AW_DEF-1:0] reg_addr_t;

  // Front-of-pipe control produced by the hazard unit.
  typedef struct packed {
    logic hold_pc;
    logic if_id_hold;
    logic id_ex_hold;
    logic stall_en;
  } hazard_ctrl_t;

  // Counter width for a given load latency; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned lat);
    return (lat == 0) ? 1 : $clog2(lat + 1);
  endfunction

endpackage

// File: rtl/load_use_scoreboard_if.sv
// Pipeline-side signals of the load-use hazard unit.
// With HAZ_STALL_STATS_EN the stall_cycles statistic is carried as well.
interface load_use_scoreboard_if #(
  parameter int unsigned REG_AW = hazard_pkg::REG_AW_DEF
);

  logic              id_ex_memread;
  logic [REG_AW-1:0] id_ex_rt;
  logic [REG_AW-1:0] if_id_rs;
  logic [REG_AW-1:0] if_id_rt;
  logic              if_id_uses_rt;
  logic              if_id_flush;
  logic              mem_ready;
  logic              hold_pc;
  logic              if_id_hold;
  logic              id_ex_hold;
  logic              stall_en;
`ifdef HAZ_STALL_STATS_EN
  logic [31:0]       stall_cycles;
`endif

  // Pipeline side: drives decode/memory status, receives hold/bubble controls.
  modport master (
`ifdef HAZ_STALL_STATS_EN
    input  stall_cycles,
`endif
    output id_ex_memread, id_ex_rt, if_id_rs, if_id_rt,
    output if_id_uses_rt, if_id_flush, mem_ready,
    input  hold_pc, if_id_hold, id_ex_hold, stall_en
  );

  // Hazard unit side.
  modport slave (
`ifdef HAZ_STALL_STATS_EN
    output stall_cycles,
`endif
    input  id_ex_memread, id_ex_rt, if_id_rs, if_id_rt,
    input  if_id_uses_rt, if_id_flush, mem_ready,
    output hold_pc, if_id_hold, id_ex_hold, stall_en
  );

endinterface

// File: rtl/load_use_scoreboard_sb_counter.sv
// Per-register pending-load down-counter; busy while the load data is not yet forwardable.
module sb_counter
  import hazard_pkg::*;
#(
  parameter int unsigned LAT = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic dec_en,
  output logic busy
);

  localparam int unsigned W = cnt_width(LAT);

  generate
    if (LAT == 0) begin : g_none
      // Zero latency: the ID/EX compare alone covers the single bubble.
      assign busy = 1'b0;
    end else begin : g_cnt
      logic [W-1:0] cnt;

      // A new issue takes priority over decay of an older load.
      always_ff @(posedge clk) begin
        if (rst) begin
          cnt <= '0;
        end else if (load) begin
          cnt <= W'(LAT);
        end else if (dec_en && (cnt != '0)) begin
          cnt <= cnt - W'(1);
        end
      end

      assign busy = (cnt != '0);
    end
  endgenerate

endmodule

// File: rtl/load_use_scoreboard.sv
// Load-use hazard unit with per-register pending-load scoreboard and memory-wait freeze.
// Define HAZ_STALL_STATS_EN to add the saturating stall_cycles counter.
module load_use_scoreboard
  import hazard_pkg::*;
#(
  parameter int unsigned REG_AW   = REG_AW_DEF,
  parameter int unsigned NUM_REGS = NUM_REGS_DEF,
  parameter int unsigned LOAD_LAT = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  load_use_scoreboard_if.slave  bus
);

  logic [NUM_REGS-1:0] load;
  logic [NUM_REGS-1:0] busy;
  logic                rs_match;
  logic                rt_match;
  logic                raw;
  hazard_ctrl_t        ctrl;

  // $0 never gets a counter load, so its busy bit stays low.
  for (genvar r = 0; r < NUM_REGS; r++) begin : g_sb
    assign load[r] = (r != 0) && bus.id_ex_memread && bus.mem_ready &&
                     (bus.id_ex_rt == REG_AW'(r));

    sb_counter #(
      .LAT (LOAD_LAT)
    ) u_cnt (
      .clk    (clk),
      .rst    (rst),
      .load   (load[r]),
      .dec_en (bus.mem_ready),
      .busy   (busy[r])
    );
  end

  // Source match against the load in ID/EX or any still-pending load.
  always_comb begin
    rs_match = 1'b0;
    rt_match = 1'b0;
    if (bus.if_id_rs != '0) begin
      rs_match = (bus.id_ex_memread && (bus.id_ex_rt == bus.if_id_rs)) ||
                 busy[bus.if_id_rs];
    end
    if (bus.if_id_uses_rt && (bus.if_id_rt != '0)) begin
      rt_match = (bus.id_ex_memread && (bus.id_ex_rt == bus.if_id_rt)) ||
                 busy[bus.if_id_rt];
    end
    raw = (rs_match || rt_match) && !bus.if_id_flush;
  end

  // Reset beats memory wait, which beats the RAW bubble.
  always_comb begin
    ctrl = '0;
    if (rst) begin
      ctrl = '0;
    end else if (!bus.mem_ready) begin
      ctrl.hold_pc    = 1'b1;
      ctrl.if_id_hold = 1'b1;
      ctrl.id_ex_hold = 1'b1;
    end else if (raw) begin
      ctrl.hold_pc    = 1'b1;
      ctrl.if_id_hold = 1'b1;
      ctrl.stall_en   = 1'b1;
    end
  end

  assign bus.hold_pc    = ctrl.hold_pc;
  assign bus.if_id_hold = ctrl.if_id_hold;
  assign bus.id_ex_hold = ctrl.id_ex_hold;
  assign bus.stall_en   = ctrl.stall_en;

`ifdef HAZ_STALL_STATS_EN
  logic [31:0] stall_cnt;

  // Counts cycles in which a RAW bubble is actually inserted.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (raw && bus.mem_ready && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + 32'(1);
    end
  end

  assign bus.stall_cycles = stall_cnt;
`endif

endmodule
